// File: rtl/uc_pkg.sv
// Shared constants for the multi-cycle control unit: opcode map, ALU select codes
// and FSM state encoding.
package uc_pkg;

    // Opcode values; anything at or above OP_LIMIT is illegal.
    localparam int unsigned OP_ADD   = 0;
    localparam int unsigned OP_SUB   = 1;
    localparam int unsigned OP_LOAD  = 2;
    localparam int unsigned OP_STORE = 3;
    localparam int unsigned OP_AND   = 4;
    localparam int unsigned OP_LIMIT = 5;

    // ALU operation select codes.
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_ADDR = 2'b10;
    localparam logic [1:0] ALU_AND  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

endpackage

// File: rtl/uc_decode.sv
// Combinational opcode decoder: opcode -> {alu_op, is_mem, is_load, is_legal}.
// Illegal opcodes decode to all-zero controls.
module uc_decode
    import uc_pkg::*;
#(
    parameter int unsigned OPCODE_W = 4
) (
    input  logic [OPCODE_W-1:0] opcode,
    output logic [1:0]          alu_op,
    output logic                is_mem,
    output logic                is_load,
    output logic                is_legal
);

    // Map each legal opcode onto its ALU select and memory class.
    always_comb begin
        alu_op   = ALU_ADD;
        is_mem   = 1'b0;
        is_load  = 1'b0;
        is_legal = 1'b1;
        case (opcode)
            OPCODE_W'(OP_ADD):   alu_op = ALU_ADD;
            OPCODE_W'(OP_SUB):   alu_op = ALU_SUB;
            OPCODE_W'(OP_LOAD): begin
                alu_op  = ALU_ADDR;
                is_mem  = 1'b1;
                is_load = 1'b1;
            end
            OPCODE_W'(OP_STORE): begin
                alu_op = ALU_ADDR;
                is_mem = 1'b1;
            end
            OPCODE_W'(OP_AND):   alu_op = ALU_AND;
            default:             is_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/uc_multicycle.sv
// Multi-cycle control unit: walks each instruction through IDLE/DECODE/EXEC/MEM/WB
// and drives ALU, data-memory and register-file controls.
// Optional macro UC_MEM_TIMEOUT_EN: abort a memory access after TIMEOUT_CYC
// consecutive MEM cycles without mem_ack, pulsing mem_err.
module uc_multicycle
    import uc_pkg::*;
#(
    parameter int unsigned OPCODE_W    = 4,
    parameter int unsigned ALUOP_W     = 2,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [OPCODE_W-1:0] opcode,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                mem_read,
    output logic                mem_write,
    input  logic                mem_ack,
    output logic                reg_write,
    output logic                done,
    output logic                illegal,
    output logic                mem_err
);

    // Elaboration-time parameter sanity checks.
    if (ALUOP_W < 2) begin : g_bad_aluop_w
        $error("uc_multicycle: ALUOP_W must be >= 2");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("uc_multicycle: TIMEOUT_CYC must be >= 1");
    end

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;

    logic [1:0] dec_alu_op;
    logic       dec_is_mem;
    logic       dec_is_load;
    logic       dec_is_legal;

    uc_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .opcode   (opcode_q),
        .alu_op   (dec_alu_op),
        .is_mem   (dec_is_mem),
        .is_load  (dec_is_load),
        .is_legal (dec_is_legal)
    );

`ifdef UC_MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout;

    // Count consecutive un-acked MEM cycles; cleared on the way into MEM.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_EXEC) begin
            cnt_d = '0;
        end else if (state_q == S_MEM && !mem_ack) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Timeout fires in the last allowed MEM cycle; an ack in that cycle wins.
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) && !mem_ack;

    // Timeout counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // State and latched-opcode registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    // Next-state and output decode from the state and the latched opcode.
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        instr_ready = 1'b0;
        alu_op      = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        mem_err     = 1'b0;
        // Outputs are forced to the IDLE values while reset is asserted.
        if (rst) begin
            instr_ready = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    instr_ready = 1'b1;
                    if (instr_valid) begin
                        opcode_d = opcode;
                        state_d  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_op = ALUOP_W'(dec_alu_op);
                    if (dec_is_legal) begin
                        state_d = S_EXEC;
                    end else begin
                        illegal = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_EXEC: begin
                    alu_op  = ALUOP_W'(dec_alu_op);
                    state_d = dec_is_mem ? S_MEM : S_WB;
                end
                S_MEM: begin
                    alu_op    = ALUOP_W'(dec_alu_op);
                    mem_read  = dec_is_load;
                    mem_write = !dec_is_load;
                    if (mem_ack) begin
                        // Stores retire here; loads still need the write-back.
                        if (dec_is_load) begin
                            state_d = S_WB;
                        end else begin
                            done    = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
`ifdef UC_MEM_TIMEOUT_EN
                    else if (timeout) begin
                        mem_err = 1'b1;
                        state_d = S_IDLE;
                    end
`endif
                end
                S_WB: begin
                    alu_op    = ALUOP_W'(dec_alu_op);
                    reg_write = 1'b1;
                    done      = 1'b1;
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uc_multicycle.sv
// Directed bench for uc_multicycle: a per-cycle vector table plus hand-written
// multi-cycle sequences (memory latency, and timeout when UC_MEM_TIMEOUT_EN is set).
module tb_uc_multicycle;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [3:0] opcode = '0;
    logic [1:0] alu_op;
    logic       mem_read, mem_write, mem_ack = 1'b0;
    logic       reg_write, done, illegal, mem_err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uc_multicycle #(
        .OPCODE_W    (4),
        .ALUOP_W     (2),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .alu_op      (alu_op),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_ack     (mem_ack),
        .reg_write   (reg_write),
        .done        (done),
        .illegal     (illegal),
        .mem_err     (mem_err)
    );

    // exp = {ready, alu_op[1:0], mem_read, mem_write, reg_write, done, illegal, mem_err}
    typedef struct packed {
        logic       rst;
        logic       valid;
        logic [3:0] op;
        logic       ack;
        logic [8:0] exp;
    } vec_t;

    localparam logic [8:0] E_IDLE  = 9'b1_00_000000;
    localparam logic [8:0] E_ADD   = 9'b0_00_000000;
    localparam logic [8:0] E_ADDWB = 9'b0_00_001100;
    localparam logic [8:0] E_SUB   = 9'b0_01_000000;
    localparam logic [8:0] E_SUBWB = 9'b0_01_001100;
    localparam logic [8:0] E_ADR   = 9'b0_10_000000;
    localparam logic [8:0] E_LDMEM = 9'b0_10_100000;
    localparam logic [8:0] E_LDWB  = 9'b0_10_001100;
    localparam logic [8:0] E_STACK = 9'b0_10_010100;
    localparam logic [8:0] E_ILL   = 9'b0_00_000010;
    localparam logic [8:0] E_AND   = 9'b0_11_000000;
    localparam logic [8:0] E_ANDWB = 9'b0_11_001100;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic v, logic [3:0] op, logic a, logic [8:0] e);
        vec_t x;
        x.rst = r; x.valid = v; x.op = op; x.ack = a; x.exp = e;
        return x;
    endfunction

    function automatic logic [8:0] outs();
        return {instr_ready, alu_op, mem_read, mem_write, reg_write, done, illegal, mem_err};
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // One clock: drive on the falling edge, outputs settle 1 time unit later.
    task automatic cyc(input logic v, input logic [3:0] op, input logic a);
        @(negedge clk);
        rst = 1'b0; instr_valid = v; opcode = op; mem_ack = a;
        #1;
    endtask

    int n_mr, n_mw, n_rw, n_dn, n_me, n_ill, first_dn, n_dn_mw;

    task automatic clear_counts();
        n_mr = 0; n_mw = 0; n_rw = 0; n_dn = 0; n_me = 0; n_ill = 0;
        first_dn = -1; n_dn_mw = 0;
    endtask

    task automatic tally(input int k);
        n_mr += int'(mem_read);
        n_mw += int'(mem_write);
        n_rw += int'(reg_write);
        n_dn += int'(done);
        n_me += int'(mem_err);
        n_ill += int'(illegal);
        n_dn_mw += int'(done & mem_write);
        if (done && first_dn < 0) first_dn = k;
        if (mem_read && mem_write) begin
            n_vec++; n_bad++;
            $display("FAIL rd_wr_overlap: mem_read=1 mem_write=1 at step %0d, expected not both", k);
        end
    endtask

    initial begin
        // Cycle-by-cycle table.
        tbl.push_back(mk(1, 0, 4'd0, 0, E_IDLE));   // reset
        tbl.push_back(mk(0, 1, 4'd0, 0, E_IDLE));   // ADD accepted (cycle 0)
        tbl.push_back(mk(0, 1, 4'd1, 0, E_ADD));    // DECODE; SUB waits on the bus
        tbl.push_back(mk(0, 1, 4'd1, 0, E_ADD));    // EXEC
        tbl.push_back(mk(0, 1, 4'd1, 0, E_ADDWB));  // WB
        tbl.push_back(mk(0, 1, 4'd1, 0, E_IDLE));   // SUB accepted (cycle 4)
        tbl.push_back(mk(0, 1, 4'd1, 0, E_SUB));
        tbl.push_back(mk(0, 1, 4'd1, 0, E_SUB));
        tbl.push_back(mk(0, 1, 4'd1, 0, E_SUBWB));
        tbl.push_back(mk(0, 1, 4'd2, 0, E_IDLE));   // LOAD accepted
        tbl.push_back(mk(0, 0, 4'd2, 0, E_ADR));
        tbl.push_back(mk(0, 0, 4'd2, 0, E_ADR));
        tbl.push_back(mk(0, 0, 4'd2, 0, E_LDMEM));  // MEM, ack delayed 3 cycles
        tbl.push_back(mk(0, 0, 4'd2, 0, E_LDMEM));
        tbl.push_back(mk(0, 0, 4'd2, 0, E_LDMEM));
        tbl.push_back(mk(0, 0, 4'd2, 1, E_LDMEM));
        tbl.push_back(mk(0, 0, 4'd2, 0, E_LDWB));
        tbl.push_back(mk(0, 1, 4'd3, 0, E_IDLE));   // STORE accepted
        tbl.push_back(mk(0, 0, 4'd3, 0, E_ADR));
        tbl.push_back(mk(0, 0, 4'd3, 0, E_ADR));
        tbl.push_back(mk(0, 0, 4'd3, 1, E_STACK));  // ack in first MEM cycle, done here
        tbl.push_back(mk(0, 1, 4'hA, 0, E_IDLE));   // illegal opcode accepted
        tbl.push_back(mk(0, 0, 4'hA, 0, E_ILL));
        tbl.push_back(mk(0, 0, 4'hA, 0, E_IDLE));
        tbl.push_back(mk(0, 1, 4'd4, 1, E_IDLE));   // AND; stray ack ignored throughout
        tbl.push_back(mk(0, 0, 4'd4, 1, E_AND));
        tbl.push_back(mk(0, 0, 4'd4, 1, E_AND));
        tbl.push_back(mk(0, 0, 4'd4, 1, E_ANDWB));
        tbl.push_back(mk(0, 1, 4'd2, 0, E_IDLE));   // LOAD, then reset mid-MEM
        tbl.push_back(mk(0, 0, 4'd2, 0, E_ADR));
        tbl.push_back(mk(0, 0, 4'd2, 0, E_ADR));
        tbl.push_back(mk(0, 0, 4'd2, 0, E_LDMEM));
        tbl.push_back(mk(1, 0, 4'd2, 0, E_IDLE));   // asynchronous: seen before the edge
        tbl.push_back(mk(0, 0, 4'd2, 0, E_IDLE));
        tbl.push_back(mk(0, 0, 4'd2, 0, E_IDLE));
        tbl.push_back(mk(0, 1, 4'd5, 0, E_IDLE));   // first illegal opcode value
        tbl.push_back(mk(0, 0, 4'd5, 0, E_ILL));
        tbl.push_back(mk(0, 0, 4'd5, 0, E_IDLE));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].rst; instr_valid = tbl[i].valid;
            opcode = tbl[i].op; mem_ack = tbl[i].ack;
            #1;
            n_vec++;
            if (outs() !== tbl[i].exp) begin
                n_bad++;
                $display("FAIL vec%0d: outputs %b, expected %b", i, outs(), tbl[i].exp);
            end
        end

        // LOAD with ack in the first MEM cycle: done lands at N+4.
        clear_counts();
        cyc(1, 4'd2, 0);
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 4'd2, k == 3);
            tally(k);
        end
        check("load_fast_done_cycle", first_dn, 4);
        check("load_fast_mem_read", n_mr, 1);
        check("load_fast_mem_write", n_mw, 0);
        check("load_fast_reg_write", n_rw, 1);

        // STORE with ack after two wait cycles: done coincides with the acked cycle.
        clear_counts();
        cyc(1, 4'd3, 0);
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 4'd3, k == 5);
            tally(k);
        end
        check("store_slow_mem_write", n_mw, 3);
        check("store_slow_done", n_dn, 1);
        check("store_slow_done_with_write", n_dn_mw, 1);
        check("store_slow_reg_write", n_rw, 0);
        check("store_slow_mem_read", n_mr, 0);
        check("store_slow_mem_err", n_me, 0);

`ifdef UC_MEM_TIMEOUT_EN
        // LOAD, no ack: four MEM cycles then a single mem_err, no retirement.
        clear_counts();
        cyc(1, 4'd2, 0);
        for (int k = 1; k <= 12; k++) begin
            cyc(0, 4'd2, 0);
            tally(k);
        end
        check("to_mem_read_cycles", n_mr, 4);
        check("to_mem_err_pulses", n_me, 1);
        check("to_done", n_dn, 0);
        check("to_reg_write", n_rw, 0);
        check("to_back_idle", int'(instr_ready), 1);

        // LOAD with ack in the 4th MEM cycle: ack wins over the timeout.
        clear_counts();
        cyc(1, 4'd2, 0);
        for (int k = 1; k <= 12; k++) begin
            cyc(0, 4'd2, k == 6);
            tally(k);
        end
        check("to_ack_mem_read_cycles", n_mr, 4);
        check("to_ack_mem_err", n_me, 0);
        check("to_ack_done", n_dn, 1);
        check("to_ack_done_cycle", first_dn, 7);
        check("to_ack_reg_write", n_rw, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

endmodule
